div_share_ctrl: RTL and testbench

- Sequencer and round-robin arbiter that shares one multi-cycle divider core between two requesters.
- Accepts operand pairs over valid/ready, drives the core's clock enable and active-low reset, and counts the core's fixed iteration latency.
- Captures the quotient and returns it to the owning requester over a valid/ready response channel.
- Sits between client logic and the divider datapath; it is the only block that touches the core's E/RN pins.

---
 rtl/div_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_share_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin sequencer sharing one multi-cycle divider core between two requesters.
// Latency C_DIV_CYCLES+2 accept-to-response (1 for b==0); response held until rspN_ready, no accept meanwhile.
module div_share_ctrl #(
    parameter int C_NUM_BITS   = 24,
    parameter int C_DIV_CYCLES = 26,
    parameter int C_CNT_BITS   = 5
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [C_NUM_BITS-1:0] req0_a,
    input  logic [C_NUM_BITS-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [C_NUM_BITS-1:0] req1_a,
    input  logic [C_NUM_BITS-1:0] req1_b,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    input  logic                  rsp0_ready,
    input  logic                  rsp1_ready,
    output logic [C_NUM_BITS-1:0] rsp_q,
    output logic                  rsp_err,
    output logic                  div_e,
    output logic                  div_rn,
    output logic [C_NUM_BITS-1:0] div_a,
    output logic [C_NUM_BITS-1:0] div_b,
    input  logic [C_NUM_BITS-1:0] div_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [C_CNT_BITS-1:0] CNT_LAST = C_CNT_BITS'(C_DIV_CYCLES - 1);
    localparam logic [C_CNT_BITS-1:0] CNT_ONE  = C_CNT_BITS'(1);

    state_t                  state;
    logic                    rr_ptr;
    logic                    owner;
    logic [C_CNT_BITS-1:0]   cnt;
    logic [C_NUM_BITS-1:0]   cap_a;
    logic [C_NUM_BITS-1:0]   cap_b;

    logic                    gnt_any;
    logic                    gnt_id;
    logic                    accept;
    logic                    rsp_done;
    logic [C_NUM_BITS-1:0]   sel_a;
    logic [C_NUM_BITS-1:0]   sel_b;

    // rr_ptr only breaks ties; a lone requester is always granted.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        sel_a   = gnt_id ? req1_a : req0_a;
        sel_b   = gnt_id ? req1_b : req0_b;
    end

    // Gating with RN keeps a grant from appearing while reset is being sampled.
    assign accept     = (state == IDLE) && RN && gnt_any;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    // Only the owner's valid is ever high, so the other ready is ignored.
    assign rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign div_a = cap_a;
    assign div_b = cap_b;

    always_ff @(posedge CK) begin
        if (!RN) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            cnt        <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_q      <= '0;
            rsp_err    <= 1'b0;
            div_e      <= 1'b0;
            div_rn     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        owner  <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        if (sel_b == '0) begin
                            // Divide by zero never touches the core.
                            state      <= RESP;
                            rsp_q      <= '1;
                            rsp_err    <= 1'b1;
                            rsp0_valid <= ~gnt_id;
                            rsp1_valid <= gnt_id;
                        end else begin
                            state  <= LOAD;
                            div_e  <= 1'b1;
                            div_rn <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    state  <= RUN;
                    div_rn <= 1'b1;
                    cnt    <= '0;
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        rsp_q      <= div_q;
                        rsp_err    <= 1'b0;
                        div_e      <= 1'b0;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        state      <= IDLE;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        div_rn     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: transaction-level timeline model plus directed literal checks.
module tb_div_share_ctrl;

    localparam int NB  = 24;
    localparam int DC  = 26;
    localparam int CB  = 5;
    localparam int LAT = DC + 2;

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [NB-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [NB-1:0] rsp_q;
    logic          rsp_err;
    logic          div_e, div_rn;
    logic [NB-1:0] div_a, div_b, div_q;

    always #5 CK = ~CK;

    div_share_ctrl #(.C_NUM_BITS(NB), .C_DIV_CYCLES(DC), .C_CNT_BITS(CB)) dut (
        .CK(CK), .RN(RN),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err),
        .div_e(div_e), .div_rn(div_rn), .div_a(div_a), .div_b(div_b), .div_q(div_q)
    );

    // Stub core: quotient appears only after DC enabled edges counted from the reset edge.
    int core_cnt = 0;
    always @(posedge CK)
        if (div_e) core_cnt <= div_rn ? ((core_cnt < 63) ? core_cnt + 1 : core_cnt) : 1;
    assign div_q = (core_cnt >= DC) ? ((div_b == '0) ? '1 : div_a / div_b)
                                    : (24'hA5A5A5 ^ NB'(core_cnt));

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: transaction timeline by cycle offset from the accept cycle.
    bit            m_live = 0, m_busy = 0, m_owner = 0, m_zero = 0, m_rr = 0, m_fresh = 0, prev_v = 0;
    logic [NB-1:0] m_a = '0, m_b = '0;
    int            m_acc = 0;
    int            acc_cyc[$], acc_own[$], rsp_cyc[$], rsp_own[$];
    logic [NB-1:0] rsp_qlog[$];
    bit            rsp_errlog[$];

    always @(negedge CK) begin
        int k;
        bit g_any, g_id, e_r0, e_r1, in_rsp, e_e, e_rn;
        cyc++;
        if (!m_live) begin
            if (!RN) begin
                m_live = 1; m_busy = 0; m_rr = 0; m_a = '0; m_b = '0; m_fresh = 1;
            end
        end else begin
            k      = cyc - m_acc;
            g_any  = req0_valid | req1_valid;
            g_id   = (req0_valid && req1_valid) ? m_rr : req1_valid;
            e_r0   = !m_busy && RN && g_any && !g_id;
            e_r1   = !m_busy && RN && g_any && g_id;
            in_rsp = m_busy && (m_zero ? (k >= 1) : (k >= LAT));
            e_e    = m_busy && !m_zero && k >= 1 && k <= DC + 1;
            e_rn   = m_busy && !m_zero && k >= 2;
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("rsp0_valid", rsp0_valid, in_rsp && !m_owner);
            chk("rsp1_valid", rsp1_valid, in_rsp && m_owner);
            chk("div_e", div_e, e_e);
            chk("div_rn", div_rn, e_rn);
            chk("div_a", div_a, m_a);
            chk("div_b", div_b, m_b);
            if (in_rsp) begin
                chk("rsp_q", rsp_q, m_zero ? {NB{1'b1}} : m_a / m_b);
                chk("rsp_err", rsp_err, m_zero);
            end else if (m_fresh) begin
                chk("rsp_q_reset", rsp_q, 0);
                chk("rsp_err_reset", rsp_err, 0);
            end
            if ((rsp0_valid || rsp1_valid) && !prev_v) begin
                rsp_cyc.push_back(cyc); rsp_own.push_back(rsp1_valid);
                rsp_qlog.push_back(rsp_q); rsp_errlog.push_back(rsp_err);
            end
            prev_v = rsp0_valid || rsp1_valid;
            if (!RN) begin
                m_busy = 0; m_rr = 0; m_a = '0; m_b = '0; m_fresh = 1;
            end else if (!m_busy) begin
                if (g_any) begin
                    m_busy = 1; m_owner = g_id; m_rr = !g_id; m_acc = cyc; m_fresh = 0;
                    m_a = g_id ? req1_a : req0_a;
                    m_b = g_id ? req1_b : req0_b;
                    m_zero = (m_b == '0);
                    acc_cyc.push_back(cyc); acc_own.push_back(g_id);
                end
            end else if (in_rsp && (m_owner ? rsp1_ready : rsp0_ready)) begin
                m_busy = 0;
            end
        end
    end

    task automatic send(input bit id, input logic [NB-1:0] a, input logic [NB-1:0] b);
        int  t = 0;
        bit  done = 0;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        while (!done && t < 400) begin
            @(negedge CK);
            t++;
            if (id ? req1_ready : req0_ready) done = 1;
        end
        @(posedge CK); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_cyc.size() < n && t < 300) begin
            @(negedge CK);
            t++;
        end
        chk("rsp_arrived", rsp_cyc.size() >= n, 1);
        repeat (2) @(posedge CK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int i0, r0, t;
        // Reset
        RN = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        @(negedge CK);
        chk("rst_div_rn", div_rn, 0);
        chk("rst_div_e", div_e, 0);
        chk("rst_rsp_q", rsp_q, 0);
        @(posedge CK); #1;
        RN = 1'b1;
        @(posedge CK); #1;

        // Single request 10/3
        i0 = acc_cyc.size(); r0 = rsp_cyc.size();
        send(0, 24'd10, 24'd3);
        wait_rsp(r0 + 1);
        chk("t1_owner", rsp_own[r0], 0);
        chk("t1_latency", rsp_cyc[r0] - acc_cyc[i0], 28);
        chk("t1_q", rsp_qlog[r0], 3);
        chk("t1_err", rsp_errlog[r0], 0);

        // Simultaneous from reset, then continuous alternation
        i0 = acc_cyc.size(); r0 = rsp_cyc.size();
        RN = 1'b0;
        fork
            send(0, 24'd100, 24'd7);
            send(1, 24'd81, 24'd9);
            begin @(posedge CK); @(posedge CK); #1; RN = 1'b1; end
        join
        fork send(0, 24'd50, 24'd5);    send(1, 24'd7, 24'd2);     join
        fork send(0, 24'd1000, 24'd8);  send(1, 24'd999, 24'd3);   join
        fork send(0, 24'hFFFFFF, 24'd1); send(1, 24'd12, 24'd13);  join
        fork send(0, 24'd4096, 24'd64); send(1, 24'd77, 24'd11);   join
        wait_rsp(r0 + 10);
        for (int i = 0; i < 10; i++) chk("rr_order", acc_own[i0 + i], i % 2);
        chk("t2_q0", rsp_qlog[r0], 14);
        chk("t2_q1", rsp_qlog[r0 + 1], 9);
        chk("t2_own1", rsp_own[r0 + 1], 1);
        chk("t2_q2", rsp_qlog[r0 + 2], 10);
        chk("t2_q6", rsp_qlog[r0 + 6], 24'hFFFFFF);

        // Divide by zero on requester 1
        i0 = acc_cyc.size(); r0 = rsp_cyc.size();
        send(1, 24'd5, 24'd0);
        wait_rsp(r0 + 1);
        chk("dz_latency", rsp_cyc[r0] - acc_cyc[i0], 1);
        chk("dz_q", rsp_qlog[r0], 24'hFFFFFF);
        chk("dz_err", rsp_errlog[r0], 1);
        chk("dz_owner", rsp_own[r0], 1);

        // Backpressure on requester 0 with requester 1 waiting
        i0 = acc_cyc.size(); r0 = rsp_cyc.size();
        rsp0_ready = 1'b0;
        send(0, 24'd1000, 24'd10);
        t = 0;
        while (!rsp0_valid && t < 100) begin @(negedge CK); t++; end
        chk("bp_valid1", rsp0_valid, 1);
        chk("bp_q1", rsp_q, 100);
        @(posedge CK); #1;
        fork
            send(1, 24'd6, 24'd3);
            begin
                for (int i = 2; i <= 5; i++) begin
                    @(negedge CK);
                    chk("bp_valid_hold", rsp0_valid, 1);
                    chk("bp_q_hold", rsp_q, 100);
                    chk("bp_no_grant", req1_ready, 0);
                    @(posedge CK); #1;
                end
                rsp0_ready = 1'b1;
            end
        join
        wait_rsp(r0 + 2);
        chk("bp_next_accept", acc_cyc[i0 + 1] - rsp_cyc[r0], 6);
        chk("bp_q_req1", rsp_qlog[r0 + 1], 2);

        // Reset while RUN counter is 10
        r0 = rsp_cyc.size();
        send(0, 24'd200, 24'd4);
        repeat (11) @(posedge CK);
        #1;
        RN = 1'b0;
        @(negedge CK);
        chk("mr_running", div_e, 1);
        @(posedge CK); #1;
        RN = 1'b1;
        @(negedge CK);
        chk("mr_div_e", div_e, 0);
        chk("mr_div_rn", div_rn, 0);
        chk("mr_div_a", div_a, 0);
        chk("mr_rsp0", rsp0_valid, 0);
        repeat (40) @(posedge CK);
        #1;
        chk("mr_no_rsp", rsp_cyc.size(), r0);
        send(0, 24'd9, 24'd3);
        wait_rsp(r0 + 1);
        chk("mr_fresh_q", rsp_qlog[r0], 3);
        chk("mr_fresh_own", rsp_own[r0], 0);

        repeat (3) @(posedge CK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
